// File: rtl/fpu_issue_sched_pkg.sv
// rtl/fpu_issue_sched_pkg.sv - shared FPU op/class types and op classifier for the issue scheduler
package fpu_issue_sched_pkg;

  // 18 one-hot op bits followed by the 2-bit conversion sub-op
  typedef struct packed {
    logic       fmadd;
    logic       fmsub;
    logic       fnmadd;
    logic       fnmsub;
    logic       fadd;
    logic       fsub;
    logic       fmul;
    logic       fdiv;
    logic       fsqrt;
    logic       fsgnj;
    logic       fmin;
    logic       fmax;
    logic       fcmp;
    logic       fclass;
    logic       fmv;
    logic       fcvt_f2i;
    logic       fcvt_i2f;
    logic       fcvt_f2f;
    logic [1:0] fcvt_op;
  } fpu_operation_type;

  typedef enum logic [1:0] {FPU_CLS_MISC, FPU_CLS_PIPE, FPU_CLS_ITER} fpu_issue_class_e;

  localparam int FPU_TAG_W = 5;

  typedef struct packed {
    logic                 valid;
    logic [FPU_TAG_W-1:0] tag;
  } fpu_sched_slot_type;

  typedef struct packed {
    fpu_issue_class_e cls;
    logic             illegal;
  } fpu_op_class_t;

  function automatic fpu_op_class_t fpu_op_class(input fpu_operation_type op);
    logic [17:0]   bits;
    fpu_op_class_t r;
    bits      = op[19:2];
    r.illegal = (bits == '0) || ((bits & (bits - 18'd1)) != '0);
    if (r.illegal)
      r.cls = FPU_CLS_MISC;
    else if (op.fmadd | op.fmsub | op.fnmadd | op.fnmsub | op.fadd | op.fsub |
             op.fmul | op.fcvt_f2f | op.fcvt_i2f)
      r.cls = FPU_CLS_PIPE;
    else if (op.fdiv | op.fsqrt)
      r.cls = FPU_CLS_ITER;
    else
      r.cls = FPU_CLS_MISC;
    return r;
  endfunction

endpackage

// File: rtl/fpu_issue_sched_tag_delay.sv
// rtl/fpu_issue_sched_tag_delay.sv - flushable valid+tag shift register tracking ops in the fixed-latency pipe
module fpu_tag_delay #(
  parameter int LAT_PIPE = 4,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             tail_valid,
  output logic [TAG_W-1:0] tail_tag,
  output logic             any_valid
);

  logic [LAT_PIPE-1:0] vld;
  logic [TAG_W-1:0]    tag [LAT_PIPE];

  for (genvar i = 0; i < LAT_PIPE; i++) begin : g_stage
    if (i == 0) begin : g_head
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld[0] <= 1'b0;
          tag[0] <= '0;
        end else begin
          vld[0] <= in_valid & ~flush;
          tag[0] <= in_tag;
        end
      end
    end else begin : g_body
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld[i] <= 1'b0;
          tag[i] <= '0;
        end else begin
          vld[i] <= vld[i-1] & ~flush;
          tag[i] <= tag[i-1];
        end
      end
    end
  end

  assign tail_valid = vld[LAT_PIPE-1];
  assign tail_tag   = tag[LAT_PIPE-1];
  assign any_valid  = |vld;

endmodule

// File: rtl/fpu_issue_sched.sv
// rtl/fpu_issue_sched.sv - in-order FP op issue/retire scheduler with a single registered writeback port
module fpu_issue_sched
  import fpu_issue_sched_pkg::*;
#(
  parameter int LAT_PIPE = 4,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [19:0]      req_op,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             misc_valid,
  input  logic [63:0]      misc_result,
  input  logic [4:0]       misc_flags,
  output logic             pipe_valid,
  input  logic             pipe_ready,
  input  logic [63:0]      pipe_result,
  input  logic [4:0]       pipe_flags,
  output logic             iter_valid,
  output logic             iter_kill,
  input  logic             iter_ready,
  input  logic [63:0]      iter_result,
  input  logic [4:0]       iter_flags,
  output logic             res_valid,
  output logic [TAG_W-1:0] res_tag,
  output logic [63:0]      res_result,
  output logic [4:0]       res_flags,
  output logic             res_illegal,
  output logic             busy,
  output logic             err_proto
);

  typedef enum logic {ITER_IDLE, ITER_BUSY} iter_state_e;

  iter_state_e      iter_state;
  logic [TAG_W-1:0] iter_tag;
  logic             iter_wb;
  logic             run;
  fpu_op_class_t    dec;
  logic             iter_busy, accept;
  logic             misc_cap, pipe_cap, iter_cap;
  logic             tail_valid, pipe_inflight;
  logic [TAG_W-1:0] tail_tag;
  logic             unused_fcvt_op;

  assign dec            = fpu_op_class(fpu_operation_type'(req_op));
  assign unused_fcvt_op = ^req_op[1:0];

  // iter_wb keeps issue closed through the ITER writeback cycle
  assign iter_busy = (iter_state == ITER_BUSY) | iter_wb;
  assign req_ready = run & ~flush & ~iter_busy &
                     ((dec.cls == FPU_CLS_PIPE) | ~pipe_inflight);
  assign accept    = req_valid & req_ready;

  assign misc_cap   = accept & (dec.cls == FPU_CLS_MISC);
  assign misc_valid = misc_cap & ~dec.illegal;
  assign pipe_valid = accept & (dec.cls == FPU_CLS_PIPE);
  assign iter_valid = accept & (dec.cls == FPU_CLS_ITER);
  assign iter_kill  = flush & (iter_state == ITER_BUSY);
  assign iter_cap   = ~flush & (iter_state == ITER_BUSY) & iter_ready;
  assign pipe_cap   = ~flush & tail_valid & pipe_ready;
  assign busy       = pipe_inflight | iter_busy | res_valid;

  fpu_tag_delay #(.LAT_PIPE(LAT_PIPE), .TAG_W(TAG_W)) u_tag_delay (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (pipe_valid),
    .in_tag     (req_tag),
    .tail_valid (tail_valid),
    .tail_tag   (tail_tag),
    .any_valid  (pipe_inflight)
  );

  // run keeps every strobe and req_ready low while rst_n is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run       <= 1'b0;
      err_proto <= 1'b0;
    end else begin
      run <= 1'b1;
      if (pipe_ready != tail_valid)
        err_proto <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_state <= ITER_IDLE;
      iter_tag   <= '0;
      iter_wb    <= 1'b0;
    end else begin
      iter_wb <= iter_cap;
      case (iter_state)
        ITER_IDLE: begin
          if (iter_valid) begin
            iter_state <= ITER_BUSY;
            iter_tag   <= req_tag;
          end
        end
        ITER_BUSY: begin
          if (flush || iter_ready)
            iter_state <= ITER_IDLE;
        end
        default: iter_state <= ITER_IDLE;
      endcase
    end
  end

  // Sources never overlap; the priority order is only a safety net
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid   <= 1'b0;
      res_tag     <= '0;
      res_result  <= '0;
      res_flags   <= '0;
      res_illegal <= 1'b0;
    end else begin
      res_valid <= iter_cap | pipe_cap | misc_cap;
      if (iter_cap) begin
        res_tag     <= iter_tag;
        res_result  <= iter_result;
        res_flags   <= iter_flags;
        res_illegal <= 1'b0;
      end else if (pipe_cap) begin
        res_tag     <= tail_tag;
        res_result  <= pipe_result;
        res_flags   <= pipe_flags;
        res_illegal <= 1'b0;
      end else if (misc_cap) begin
        res_tag     <= req_tag;
        res_result  <= dec.illegal ? 64'd0 : misc_result;
        res_flags   <= dec.illegal ? 5'd0 : misc_flags;
        res_illegal <= dec.illegal;
      end
    end
  end

endmodule
